// File: rtl/l2_pmem_responder.sv
// Memory-side responder for the L2 cache: line-granular backing array with a fixed
// access latency, stb/cyc/resp/retry handshake, and completed read/write counters.
module l2_pmem_responder #(
    parameter int LINE_WIDTH = 256,
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_action_stb,
    input  logic                  mem_action_cyc,
    input  logic                  mem_write,
    input  logic [ADDR_WIDTH-1:0] mem_address,
    input  logic [LINE_WIDTH-1:0] mem_wdata,
    output logic [LINE_WIDTH-1:0] mem_rdata,
    output logic                  mem_resp,
    output logic                  mem_retry,
    output logic [31:0]           rd_count,
    output logic [31:0]           wr_count
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESPOND
    } state_e;

    localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

    state_e                  state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    write_q, write_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [LINE_WIDTH-1:0]   wdata_q, wdata_d;
    logic [LINE_WIDTH-1:0]   rdata_q;
    logic [31:0]             rd_q, rd_d;
    logic [31:0]             wr_q, wr_d;
    logic                    req;
    logic                    load_rdata;

    logic [LINE_WIDTH-1:0]   mem_q [2**ADDR_WIDTH];

    assign req       = mem_action_stb & mem_action_cyc;
    assign mem_resp  = (state_q == RESPOND);
    assign mem_retry = req & ~mem_resp;
    assign mem_rdata = rdata_q;
    assign rd_count  = rd_q;
    assign wr_count  = wr_q;

    // NOTE: every output of this block gets a default before the case so no path leaves a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    write_d = mem_write;
                    addr_d  = mem_address;
                    wdata_d = mem_wdata;
                    cnt_d   = LAT_M1;
                    state_d = (LATENCY == 1) ? RESPOND : ACCESS;
                end
            end
            ACCESS: begin
                if (!req) begin
                    // Initiator withdrew: drop the transaction without side effects.
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q <= 8'd1) begin
                    state_d = RESPOND;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            RESPOND: begin
                state_d = IDLE;
                if (write_q) wr_d = wr_q + 32'd1;
                else         rd_d = rd_q + 32'd1;
            end
            default: state_d = IDLE;
        endcase

        load_rdata = (state_d == RESPOND) && (state_q != RESPOND) && !write_d;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            // Read data is captured on entry to RESPOND and zeroed otherwise.
            rdata_q <= load_rdata ? mem_q[addr_d] : '0;
        end
    end

    // NOTE: the backing array is deliberately left out of reset; only the write enable sees reset.
    always_ff @(posedge clk) begin
        if (!reset && state_q == RESPOND && write_q) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_l2_pmem_responder.sv
// Directed plus randomized bench for l2_pmem_responder at LATENCY=4 and LATENCY=1,
// checked against a line-array/counter model derived from the handshake rules.
module tb_l2_pmem_responder;

    logic         clk = 1'b0;
    logic         reset;
    int           cycle = 0;
    int           errors = 0;
    int           checks = 0;

    logic         stb4, cyc4, wr4, stb1, cyc1, wr1;
    logic [9:0]   addr4, addr1;
    logic [255:0] wd4, wd1, rd4, rd1;
    logic         resp4, retry4, resp1, retry1;
    logic [31:0]  rc4, wc4, rc1, wc1;

    bit           sel;
    logic         o_resp, o_retry;
    logic [255:0] o_rdata;
    logic [31:0]  o_rc, o_wc;

    logic [255:0] mem_m4 [int];
    logic [255:0] mem_m1 [int];
    int           exp_rd [2];
    int           exp_wr [2];

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    l2_pmem_responder #(.LINE_WIDTH(256), .ADDR_WIDTH(10), .LATENCY(4)) u_dut4 (
        .clk(clk), .reset(reset), .mem_action_stb(stb4), .mem_action_cyc(cyc4),
        .mem_write(wr4), .mem_address(addr4), .mem_wdata(wd4), .mem_rdata(rd4),
        .mem_resp(resp4), .mem_retry(retry4), .rd_count(rc4), .wr_count(wc4));

    l2_pmem_responder #(.LINE_WIDTH(256), .ADDR_WIDTH(10), .LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset), .mem_action_stb(stb1), .mem_action_cyc(cyc1),
        .mem_write(wr1), .mem_address(addr1), .mem_wdata(wd1), .mem_rdata(rd1),
        .mem_resp(resp1), .mem_retry(retry1), .rd_count(rc1), .wr_count(wc1));

    assign o_resp  = sel ? resp1  : resp4;
    assign o_retry = sel ? retry1 : retry4;
    assign o_rdata = sel ? rd1    : rd4;
    assign o_rc    = sel ? rc1    : rc4;
    assign o_wc    = sel ? wc1    : wc4;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit s, input bit c, input bit w, input logic [9:0] a,
                         input logic [255:0] d);
        if (sel) begin
            stb1 = s; cyc1 = c; wr1 = w; addr1 = a; wd1 = d;
        end else begin
            stb4 = s; cyc4 = c; wr4 = w; addr4 = a; wd4 = d;
        end
    endtask

    function automatic bit m_has(input logic [9:0] a);
        return sel ? mem_m1.exists(int'(a)) : mem_m4.exists(int'(a));
    endfunction

    function automatic logic [255:0] m_get(input logic [9:0] a);
        return sel ? mem_m1[int'(a)] : mem_m4[int'(a)];
    endfunction

    task automatic m_put(input logic [9:0] a, input logic [255:0] d);
        if (sel) mem_m1[int'(a)] = d;
        else     mem_m4[int'(a)] = d;
    endtask

    function automatic int lat();
        return sel ? 1 : 4;
    endfunction

    // Samples at negedge+1 until resp is seen; got is the cycle index or -1 on timeout.
    task automatic wait_resp(output int got, output bit rok);
        got = -1;
        rok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (o_resp === 1'b1) begin
                got = cycle;
                break;
            end
            if (o_retry !== 1'b1) rok = 1'b0;
            @(negedge clk); #1;
        end
    endtask

    task automatic post_checks(input string tag);
        @(negedge clk); #1;
        chk({tag, "_resp_low"}, 256'(o_resp), 256'(1'b0));
        chk({tag, "_rdata_zero"}, o_rdata, '0);
        chk({tag, "_rd_count"}, 256'(o_rc), 256'(exp_rd[sel]));
        chk({tag, "_wr_count"}, 256'(o_wc), 256'(exp_wr[sel]));
    endtask

    task automatic xact(input string tag, input bit w, input logic [9:0] a,
                        input logic [255:0] d);
        int k0, got;
        bit rok;
        @(negedge clk);
        drive(1'b1, 1'b1, w, a, d);
        k0 = cycle;
        #1;
        wait_resp(got, rok);
        chk({tag, "_latency"}, 256'(got - k0), 256'(lat()));
        chk({tag, "_retry_wait"}, 256'(rok), 256'(1'b1));
        chk({tag, "_retry_in_resp"}, 256'(o_retry), 256'(1'b0));
        if (w) begin
            m_put(a, d);
            exp_wr[sel]++;
        end else begin
            chk({tag, "_rdata"}, o_rdata, m_get(a));
            exp_rd[sel]++;
        end
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        post_checks(tag);
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k0, g1, g2;
        bit rok, saw;
        logic [255:0] d;
        logic [9:0] a;
        bit w;

        sel = 1'b0;
        exp_rd = '{0, 0};
        exp_wr = '{0, 0};
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        sel = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        sel = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = bit'(s);
            chk("reset_resp", 256'(o_resp), 256'(1'b0));
            chk("reset_retry", 256'(o_retry), 256'(1'b0));
            chk("reset_rdata", o_rdata, '0);
            chk("reset_rd_count", 256'(o_rc), 256'(0));
            chk("reset_wr_count", 256'(o_wc), 256'(0));
        end
        sel = 1'b0;
        reset = 1'b0;

        // Read latency with a preloaded 0xA5 line.
        xact("preload", 1'b1, 10'h005, {32{8'hA5}});
        xact("read_lat", 1'b0, 10'h005, '0);

        // Write then read at the top address.
        xact("wr_top", 1'b1, 10'h3FF, {8{32'hDEADBEEF}});
        xact("rd_top", 1'b0, 10'h3FF, '0);

        // Write-back followed by fill with the request held high throughout.
        xact("pre_fill", 1'b1, 10'h020, rand_line());
        d = rand_line();
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 10'h010, d);
        k0 = cycle;
        #1;
        wait_resp(g1, rok);
        chk("b2b_wb_latency", 256'(g1 - k0), 256'(4));
        chk("b2b_wb_retry", 256'(rok), 256'(1'b1));
        m_put(10'h010, d);
        exp_wr[0]++;
        drive(1'b1, 1'b1, 1'b0, 10'h020, '0);
        @(negedge clk); #1;
        chk("b2b_bubble_resp", 256'(o_resp), 256'(1'b0));
        chk("b2b_bubble_retry", 256'(o_retry), 256'(1'b1));
        wait_resp(g2, rok);
        chk("b2b_spacing", 256'(g2 - g1), 256'(5));
        chk("b2b_fill_retry", 256'(rok), 256'(1'b1));
        chk("b2b_fill_rdata", o_rdata, m_get(10'h020));
        exp_rd[0]++;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        post_checks("b2b");
        xact("b2b_rd_wb", 1'b0, 10'h010, '0);

        // Abort: cyc drops two cycles into the access.
        xact("abort_old", 1'b1, 10'h001, rand_line());
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 10'h001, rand_line());
        repeat (2) @(negedge clk);
        cyc4 = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            if (o_resp === 1'b1) saw = 1'b1;
        end
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        chk("abort_no_resp", 256'(saw), 256'(1'b0));
        chk("abort_wr_count", 256'(o_wc), 256'(exp_wr[0]));
        xact("abort_rd_old", 1'b0, 10'h001, '0);

        // Reset during the access phase of a write.
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 10'h3FF, rand_line());
        repeat (3) @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        saw = 1'b0;
        @(negedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (o_resp === 1'b1) saw = 1'b1;
            @(negedge clk); #1;
        end
        exp_rd = '{0, 0};
        exp_wr = '{0, 0};
        chk("rst_no_resp", 256'(saw), 256'(1'b0));
        chk("rst_rd_count4", 256'(rc4), 256'(0));
        chk("rst_wr_count4", 256'(wc4), 256'(0));
        chk("rst_rd_count1", 256'(rc1), 256'(0));
        chk("rst_wr_count1", 256'(wc1), 256'(0));
        xact("rst_line_kept", 1'b0, 10'h3FF, '0);

        // Randomized traffic at LATENCY=4 over a small address window.
        for (int i = 0; i < 16; i++) begin
            a = 10'h100 + 10'($urandom_range(0, 7));
            w = !m_has(a) || ($urandom_range(0, 1) == 1);
            xact("rand4", w, a, rand_line());
        end

        // LATENCY=1 instance.
        sel = 1'b1;
        xact("l1_write", 1'b1, 10'h005, {32{8'h5A}});
        xact("l1_read", 1'b0, 10'h005, '0);
        for (int i = 0; i < 10; i++) begin
            a = 10'h200 + 10'($urandom_range(0, 3));
            w = !m_has(a) || ($urandom_range(0, 1) == 1);
            xact("rand1", w, a, rand_line());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
